multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port opcode  input  7  instruction[6:0] from the instruction register.
REQ-004 SHALL have port funct3  input  3  instruction[14:12].
REQ-005 SHALL have port funct7b5  input  1  instruction[30].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completion strobe for the current read or write.
REQ-008 SHALL have ports pc_write, ir_write, adr_src, mem_read, mem_write, reg_write  output  1 each  datapath enables and selects.
REQ-009 SHALL have ports alu_src_a, alu_src_b, result_src, alu_op, imm_sel  output  2 each  mux selects and codes; imm_sel 00=I, 01=S, 10=B to the immediate generator.
REQ-010 SHALL have ports state  output  4  current state, and illegal  output  1  sticky trap flag.
REQ-011 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BRANCH=8, TRAP=9; codes 10-15 SHALL go to TRAP.
REQ-013 FETCH: mem_read=1, adr_src=0; stay until mem_ready=1; in the mem_ready cycle ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_op=00 (PC+4); next DECODE.
REQ-014 DECODE: one cycle; alu_src_a=01, alu_src_b=01, imm_sel=10 (branch target precompute); next by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 1100011 with funct3 000/001 -> BRANCH, anything else -> TRAP.
REQ-015 imm_sel SHALL be 00 for opcode 0000011, 01 for 0100011, 10 for 1100011 in MEMADR and BRANCH; 00 elsewhere except DECODE per REQ-014.
REQ-016 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next MEMREAD for load, MEMWRITE for store.
REQ-017 MEMREAD: mem_read=1, adr_src=1; hold until mem_ready=1, then MEMWB.
REQ-018 MEMWB: reg_write=1, result_src=01; one cycle; next FETCH.
REQ-019 MEMWRITE: mem_write=1, adr_src=1; hold until mem_ready=1, then FETCH.
REQ-020 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_write=1, result_src=00; next FETCH.
REQ-021 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write = zero XOR funct3[0] (beq/bne), combinational in that cycle; next FETCH.
REQ-022 TRAP: all enables 0; illegal=1; remain in TRAP until reset.
REQ-023 mem_read and mem_write SHALL never be 1 in the same cycle; reg_write and mem_write SHALL never be 1 in the same cycle.
REQ-024 Outputs not listed for a state SHALL be 0.
REQ-025 retired SHALL increment by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, or MEMWRITE with mem_ready=1; wraps 0xFFFFFFFF -> 0; never increments in TRAP.
REQ-026 mem_ready while not in FETCH, MEMREAD or MEMWRITE SHALL be ignored.

Reset
REQ-027 While reset=1: state=FETCH, illegal=0, retired=0, and every 1-bit and 2-bit output forced to 0 (including mem_read).
REQ-028 Reset asserted mid-access (FETCH, MEMREAD, MEMWRITE) SHALL drop mem_read/mem_write immediately and abandon the access; first cycle after deassertion is FETCH with mem_read=1.

Verification
REQ-029 lw (opcode 0000011), mem_ready delayed 3 cycles in FETCH and 2 in MEMREAD -> states 0,0,0,0,1,2,3,3,3,4,0; reg_write=1 only in state 4 with result_src=01; retired=1.
REQ-030 sw (0100011), mem_ready=1 immediately -> states 0,1,2,5,0; imm_sel=01 in MEMADR; mem_write=1 for one cycle; retired=1.
REQ-031 R-type (0110011) then beq (1100011, funct3 000) with zero=1, then bne (funct3 001) with zero=1 -> ALUWB reg_write=1; beq pc_write=1 in BRANCH; bne pc_write=0; retired=3.
REQ-032 opcode 1111111 -> DECODE to TRAP, illegal=1 held 20 cycles with all enables 0, retired unchanged; reset clears to FETCH, illegal=0.
REQ-033 reset pulsed while in MEMREAD with mem_read=1 -> mem_read=0 same cycle, state=0, retired=0; after release FETCH restarts.
REQ-034 retired preloaded via force to 0xFFFFFFFF, complete one R-type -> retired=0x00000000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle load/store/R-type/branch control FSM with retire counter
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;

  logic       pc_write_c, ir_write_c, adr_src_c, mem_read_c, mem_write_c, reg_write_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c, alu_op_c, imm_sel_c;
  logic       retire_c;

  // funct7b5 is consumed by the ALU decoder, not by this sequencer
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;
    alu_op_c     = 2'b00;
    imm_sel_c    = 2'b00;
    retire_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c  = 1'b1;
          pc_write_c  = 1'b1;
          alu_src_b_c = 2'b10;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        imm_sel_c   = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        imm_sel_c   = (opcode == OP_STORE) ? 2'b01 : 2'b00;
        if (opcode == OP_LOAD)       state_d = S_MEMREAD;
        else if (opcode == OP_STORE) state_d = S_MEMWRITE;
        else                         state_d = S_TRAP;
      end
      S_MEMREAD: begin
        mem_read_c = 1'b1;
        adr_src_c  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        result_src_c = 2'b01;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        imm_sel_c   = 2'b10;
        // beq takes on zero, bne on not-zero
        pc_write_c  = zero ^ funct3[0];
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = retire_c ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are masked by reset so an in-flight memory access drops at once
  assign pc_write   = pc_write_c  & ~reset;
  assign ir_write   = ir_write_c  & ~reset;
  assign adr_src    = adr_src_c   & ~reset;
  assign mem_read   = mem_read_c  & ~reset;
  assign mem_write  = mem_write_c & ~reset;
  assign reg_write  = reg_write_c & ~reset;
  assign alu_src_a  = reset ? 2'b00 : alu_src_a_c;
  assign alu_src_b  = reset ? 2'b00 : alu_src_b_c;
  assign result_src = reset ? 2'b00 : result_src_c;
  assign alu_op     = reset ? 2'b00 : alu_op_c;
  assign imm_sel    = reset ? 2'b00 : imm_sel_c;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule
